// File: rtl/pwm_ramp_pkg.sv
// pwm_ramp_sequencer shared types and width helpers.
// Optional dwell stage: define PWM_RAMP_HOLD_EN.
package pwm_ramp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    HOLD,
    RAMP_DOWN
  } state_t;

  localparam int PERIOD_DEF = 100;
  localparam int DW_DEF     = $clog2(PERIOD_DEF + 1);

  function automatic int duty_w(input int period);
    return $clog2(period + 1);
  endfunction

endpackage

// File: rtl/pwm_core.sv
// Free-running PWM counter with period-boundary shadowed duty.
// Duty changes only take effect on the cycle after period_end.
module pwm_core
  import pwm_ramp_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF,
  parameter int DW     = duty_w(PERIOD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] duty_cmd,
  output logic          pwm_out,
  output logic          period_end
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;
  logic [DW-1:0] duty_act;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      duty_act <= '0;
    end else if (period_end) begin
      cnt      <= '0;
      duty_act <= duty_cmd;
    end else begin
      cnt      <= cnt + CW'(1);
    end
  end

  assign period_end = (cnt == LAST);
  assign pwm_out    = (DW'(cnt) < duty_act);

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Ramp-up / dwell / ramp-down duty sequencer around pwm_core.
// Dwell stage present only when PWM_RAMP_HOLD_EN is defined.
module pwm_ramp_sequencer
  import pwm_ramp_pkg::*;
#(
  parameter int PERIOD = PERIOD_DEF,
  parameter int DW     = duty_w(PERIOD),
  parameter int HW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [DW-1:0] cfg_step,
  input  logic [DW-1:0] cfg_max,
  input  logic [HW-1:0] cfg_hold,
  input  logic          abort,
  output logic          pwm_out,
  output logic [DW-1:0] duty,
  output logic          period_end,
  output logic          busy,
  output logic          done
);

  localparam logic [DW-1:0] PMAX = DW'(PERIOD);

  state_t        state, state_n;
  logic [DW-1:0] duty_q, duty_n;
  logic [DW-1:0] step_q, step_n;
  logic [DW-1:0] max_q, max_n;
  logic          done_q, done_n;
  logic [DW:0]   up_sum;
  logic [DW-1:0] up_val, dn_val;

`ifdef PWM_RAMP_HOLD_EN
  logic [HW-1:0] hcnt_q, hcnt_n;
`else
  logic unused_hold;
  assign unused_hold = ^cfg_hold;
`endif

  // Sum kept one bit wider so a large step cannot wrap past the ceiling
  assign up_sum = {1'b0, duty_q} + {1'b0, step_q};
  assign up_val = (up_sum > {1'b0, max_q}) ? max_q : up_sum[DW-1:0];
  assign dn_val = (duty_q > step_q) ? duty_q - step_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      duty_q <= '0;
      step_q <= '0;
      max_q  <= '0;
      done_q <= 1'b0;
`ifdef PWM_RAMP_HOLD_EN
      hcnt_q <= '0;
`endif
    end else begin
      state  <= state_n;
      duty_q <= duty_n;
      step_q <= step_n;
      max_q  <= max_n;
      done_q <= done_n;
`ifdef PWM_RAMP_HOLD_EN
      hcnt_q <= hcnt_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    duty_n  = duty_q;
    step_n  = step_q;
    max_n   = max_q;
    done_n  = 1'b0;
`ifdef PWM_RAMP_HOLD_EN
    hcnt_n  = hcnt_q;
`endif
    unique case (state)
      IDLE: begin
        duty_n = '0;
        if (cfg_valid) begin
          state_n = RAMP_UP;
          step_n  = (cfg_step == '0) ? DW'(1) : cfg_step;
          max_n   = (cfg_max > PMAX) ? PMAX : cfg_max;
`ifdef PWM_RAMP_HOLD_EN
          hcnt_n  = cfg_hold;
`endif
        end
      end
      RAMP_UP: begin
        if (period_end) begin
          duty_n = up_val;
          if (up_val == max_q) begin
`ifdef PWM_RAMP_HOLD_EN
            state_n = HOLD;
`else
            state_n = RAMP_DOWN;
`endif
          end
        end
      end
`ifdef PWM_RAMP_HOLD_EN
      HOLD: begin
        if (period_end) begin
          if (hcnt_q <= HW'(1)) begin
            hcnt_n  = '0;
            state_n = RAMP_DOWN;
          end else begin
            hcnt_n  = hcnt_q - HW'(1);
          end
        end
      end
`endif
      RAMP_DOWN: begin
        if (period_end) begin
          duty_n = dn_val;
          if (dn_val == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        duty_n  = '0;
      end
    endcase
    // In IDLE abort is ignored, so a simultaneous transfer wins
    if (state != IDLE && abort) begin
      state_n = IDLE;
      duty_n  = '0;
      done_n  = 1'b1;
    end
  end

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign duty      = duty_q;
  assign done      = done_q;

  pwm_core #(
    .PERIOD (PERIOD),
    .DW     (DW)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .duty_cmd   (duty_q),
    .pwm_out    (pwm_out),
    .period_end (period_end)
  );

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Scoreboard bench for pwm_ramp_sequencer (PERIOD=10).
// Expected boundary duties are queued at profile load time.
module tb_pwm_ramp_sequencer;

  localparam int P  = 10;
  localparam int DW = 4;
  localparam int HW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [DW-1:0] cfg_step;
  logic [DW-1:0] cfg_max;
  logic [HW-1:0] cfg_hold;
  logic          abort;
  logic          pwm_out;
  logic [DW-1:0] duty;
  logic          period_end;
  logic          busy;
  logic          done;

  pwm_ramp_sequencer #(
    .PERIOD (P),
    .DW     (DW),
    .HW     (HW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_step   (cfg_step),
    .cfg_max    (cfg_max),
    .cfg_hold   (cfg_hold),
    .abort      (abort),
    .pwm_out    (pwm_out),
    .duty       (duty),
    .period_end (period_end),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int q[$];
  int model_cmd = 0;
  int model_act = 0;
  int hc = 0;
  int done_cnt = 0;
  bit chk_pend = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  // Boundary monitor: duty after each busy boundary, high count per period
  always @(negedge clk) begin
    if (rst) begin
      hc = 0;
      model_cmd = 0;
      model_act = 0;
      chk_pend = 0;
      q.delete();
    end else begin
      if (chk_pend) begin
        chk_pend = 0;
        if (q.size() == 0) chk("sb_underflow", int'(duty), -1);
        else begin
          model_cmd = q.pop_front();
          chk("duty", int'(duty), model_cmd);
        end
      end
      hc += int'(pwm_out);
      if (done) done_cnt++;
      if (period_end) begin
        chk("hicnt", hc, model_act);
        model_act = model_cmd;
        hc = 0;
        if (busy) chk_pend = 1;
      end
    end
  end

  task automatic start_profile(input int step, input int mx,
                               input int hold, input bit ab);
    int b;
    int s;
    int m;
    int c;
    b = 0;
    while (!cfg_ready && b < 500) begin
      @(posedge clk); #1; b++;
    end
    chk("ready_idle", int'(cfg_ready), 1);
    s = (step == 0) ? 1 : step;
    m = (mx > P) ? P : mx;
    c = 0;
    do begin
      c = (c + s > m) ? m : c + s;
      q.push_back(c);
    end while (c != m);
`ifdef PWM_RAMP_HOLD_EN
    repeat ((hold == 0) ? 1 : hold) q.push_back(m);
`endif
    do begin
      c = (c > s) ? c - s : 0;
      q.push_back(c);
    end while (c != 0);
    cfg_step  = DW'(step);
    cfg_max   = DW'(mx);
    cfg_hold  = HW'(hold);
    cfg_valid = 1'b1;
    abort     = ab;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    abort     = 1'b0;
    chk("busy_start", int'(busy), 1);
    chk("ready_busy", int'(cfg_ready), 0);
  endtask

  task automatic finish_profile();
    int d0;
    int b;
    d0 = done_cnt;
    b = 0;
    while (!done && b < 2000) begin
      @(posedge clk); #1; b++;
    end
    chk("done_seen", int'(done), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("sb_drained", q.size(), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  task automatic wait_duty(input int v);
    int b;
    b = 0;
    while (int'(duty) != v && b < 500) begin
      @(posedge clk); #1; b++;
    end
    chk("duty_reach", int'(duty), v);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_step = '0;
    cfg_max = '0;
    cfg_hold = '0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_duty", int'(duty), 0);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pend", int'(period_end), 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    start_profile(3, 8, 2, 1'b0);
    finish_profile();

    start_profile(0, 2, 0, 1'b0);
    finish_profile();

    // abort with cfg_valid in IDLE: transfer still happens
    start_profile(4, 15, 0, 1'b1);
    finish_profile();

    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("idle_abort_busy", int'(busy), 0);
    chk("idle_abort_done", int'(done), 0);

    start_profile(3, 8, 2, 1'b0);
    wait_duty(6);
    @(posedge clk); #1;
    d0 = done_cnt;
    q.delete();
    model_cmd = 0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_duty", int'(duty), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 1);
    chk("abort_pwm_hold", int'(pwm_out), 1);
    repeat (2 * P) @(posedge clk);
    #1;
    chk("abort_done_once", done_cnt - d0, 1);

    start_profile(3, 8, 2, 1'b0);
    cfg_valid = 1'b1;
    cfg_step = 4'd1;
    cfg_max = 4'd1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("busy_no_xfer", int'(cfg_ready), 0);
    end
    cfg_valid = 1'b0;
    wait_duty(6);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_duty", int'(duty), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(cfg_ready), 1);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_pwm", int'(pwm_out), 0);
    chk("mid_rst_pend", int'(period_end), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    start_profile(2, 4, 1, 1'b0);
    finish_profile();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: run did not complete, want completion");
    $fatal(1);
  end

endmodule
